// File: rtl/zmips_pkg.sv
// Shared ZMIPS definitions: register-file geometry, reserved register
// numbers and the write-source record used by the writeback arbiter.
package zmips_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int DATA_W           = 32;
  localparam int WB_DEPTH_DEFAULT = 4;

  localparam logic [REG_ADDR_W-1:0] REG_PCSAVE = 5'd30;
  localparam logic [REG_ADDR_W-1:0] REG_PC     = 5'd31;

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_src_t;

  // PC-save and PC live outside the register file and are never written here.
  function automatic logic is_nonwritable(input logic [REG_ADDR_W-1:0] addr);
    return (addr == REG_PCSAVE) || (addr == REG_PC);
  endfunction

endpackage

// File: rtl/zmips_wb_fifo.sv
// Load-result queue for the writeback arbiter: circular buffer with
// per-entry valid bits, kill-by-address and hazard address matching.
module zmips_wb_fifo
  import zmips_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  push_vld,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_addr,
  input  logic [REG_ADDR_W-1:0] chk_addr_0,
  input  logic [REG_ADDR_W-1:0] chk_addr_1,
  output logic                  full,
  output logic                  empty,
  output wb_src_t               head,
  output logic                  match_0,
  output logic                  match_1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [DEPTH-1:0]      vld_r;
  logic [DEPTH-1:0]      vld_nxt_s;
  logic [REG_ADDR_W-1:0] addr_r [DEPTH];
  logic [DATA_W-1:0]     data_r [DEPTH];
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  assign head.vld  = vld_r[rd_ptr_r];
  assign head.addr = addr_r[rd_ptr_r];
  assign head.data = data_r[rd_ptr_r];

  // Next valid vector: kill matching entries, retire the popped slot, mark the pushed slot.
  // Popped slots are cleared so that a valid bit always implies an occupied entry.
  always_comb begin
    vld_nxt_s = vld_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en && vld_r[i] && (addr_r[i] == kill_addr)) begin
        vld_nxt_s[i] = 1'b0;
      end else begin
        vld_nxt_s[i] = vld_nxt_s[i];
      end
    end
    if (do_pop_s) begin
      vld_nxt_s[rd_ptr_r] = 1'b0;
    end else begin
      vld_nxt_s = vld_nxt_s;
    end
    if (do_push_s) begin
      vld_nxt_s[wr_ptr_r] = push_vld;
    end else begin
      vld_nxt_s = vld_nxt_s;
    end
  end

  // Hazard address match against live (valid) entries only.
  always_comb begin
    match_0 = 1'b0;
    match_1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_r[i] && (addr_r[i] == chk_addr_0)) begin
        match_0 = 1'b1;
      end else begin
        match_0 = match_0;
      end
      if (vld_r[i] && (addr_r[i] == chk_addr_1)) begin
        match_1 = 1'b1;
      end else begin
        match_1 = match_1;
      end
    end
  end

  // Pointers, occupancy and valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      vld_r    <= DEPTH'(0);
    end else begin
      vld_r <= vld_nxt_s;
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload; contents are qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      addr_r[wr_ptr_r] <= push_addr;
      data_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/zmips_wb_arb.sv
// ZMIPS register-file writeback arbiter: ALU results take priority over
// queued load results; PC registers are filtered; hazards exported to decode.
module zmips_wb_arb
  import zmips_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_vld,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  ld_vld,
  input  logic [REG_ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data,
  output logic                  ld_rdy,
  output logic                  wr,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] chk_addr_0,
  input  logic [REG_ADDR_W-1:0] chk_addr_1,
  output logic                  hazard_0,
  output logic                  hazard_1
);

  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  push_s;
  logic                  push_vld_s;
  logic                  pop_s;
  logic                  kill_en_s;
  logic                  match_0_s;
  logic                  match_1_s;
  logic                  wr_nxt_s;
  wb_src_t               head_s;
  wb_src_t               sel_s;
  logic                  wr_r;
  logic [REG_ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0]     wr_data_r;

  assign ld_rdy    = !fifo_full_s && !rst;
  assign push_s    = ld_vld && ld_rdy;
  assign pop_s     = !alu_vld && !fifo_empty_s && !rst;
  assign kill_en_s = alu_vld && !rst;
  // A load colliding with the current ALU write is older, so it enters already dead.
  assign push_vld_s = !(alu_vld && (ld_addr == alu_addr));

  zmips_wb_fifo #(
    .DEPTH (WB_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_vld   (push_vld_s),
    .push_addr  (ld_addr),
    .push_data  (ld_data),
    .pop        (pop_s),
    .kill_en    (kill_en_s),
    .kill_addr  (alu_addr),
    .chk_addr_0 (chk_addr_0),
    .chk_addr_1 (chk_addr_1),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .head       (head_s),
    .match_0    (match_0_s),
    .match_1    (match_1_s)
  );

  // Source select: ALU strictly first, then queue head, else idle.
  always_comb begin
    sel_s = '0;
    if (alu_vld) begin
      sel_s.vld  = 1'b1;
      sel_s.addr = alu_addr;
      sel_s.data = alu_data;
    end else if (!fifo_empty_s) begin
      sel_s = head_s;
    end else begin
      sel_s = '0;
    end
    wr_nxt_s = sel_s.vld && !is_nonwritable(sel_s.addr);
  end

  // Output register; address and data only move when a write actually issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_r      <= 1'b0;
      wr_addr_r <= REG_ADDR_W'(0);
      wr_data_r <= DATA_W'(0);
    end else begin
      wr_r <= wr_nxt_s;
      if (wr_nxt_s) begin
        wr_addr_r <= sel_s.addr;
        wr_data_r <= sel_s.data;
      end
    end
  end

  assign wr      = wr_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;

  // Hazard: live queued write or the write currently being retired; PC registers never stall.
  always_comb begin
    hazard_0 = 1'b0;
    hazard_1 = 1'b0;
    if (is_nonwritable(chk_addr_0)) begin
      hazard_0 = 1'b0;
    end else begin
      hazard_0 = match_0_s || (wr_r && (wr_addr_r == chk_addr_0));
    end
    if (is_nonwritable(chk_addr_1)) begin
      hazard_1 = 1'b0;
    end else begin
      hazard_1 = match_1_s || (wr_r && (wr_addr_r == chk_addr_1));
    end
  end

endmodule
